// File: rtl/lagarto_dcache_responder_if.sv
// Lagarto split load/store dcache request interface.
//
// Groups the core-facing load and store ports of the dcache responder.
// Signal names carry the direction suffix as seen from the responder.
//   slave  : responder side (cache); consumes requests, drives grants and load data.
//   master : core side; drives requests, consumes grants and load data.
//
// Load port  : ld_req_valid_i/ld_addr_index_i -> ld_gnt_o (index phase),
//              ld_tag_valid_i/ld_addr_tag_i/ld_kill_i (tag phase),
//              ld_rvalid_o/ld_rdata_o (response).
// Store port : st_req_valid_i/st_we_i/st_addr_index_i/st_addr_tag_i/st_wdata_i/st_be_i
//              -> st_gnt_o.
interface lagarto_dcache_responder_if #(
  parameter int unsigned INDEX_W = 12,
  parameter int unsigned TAG_W   = 44
);
  // Load port
  logic               ld_req_valid_i;
  logic [INDEX_W-1:0] ld_addr_index_i;
  logic               ld_gnt_o;
  logic               ld_tag_valid_i;
  logic [TAG_W-1:0]   ld_addr_tag_i;
  logic               ld_kill_i;
  logic               ld_rvalid_o;
  logic [63:0]        ld_rdata_o;

  // Store port
  logic               st_req_valid_i;
  logic               st_we_i;
  logic [INDEX_W-1:0] st_addr_index_i;
  logic [TAG_W-1:0]   st_addr_tag_i;
  logic [63:0]        st_wdata_i;
  logic [7:0]         st_be_i;
  logic               st_gnt_o;

  modport slave (
    input  ld_req_valid_i,
    input  ld_addr_index_i,
    output ld_gnt_o,
    input  ld_tag_valid_i,
    input  ld_addr_tag_i,
    input  ld_kill_i,
    output ld_rvalid_o,
    output ld_rdata_o,
    input  st_req_valid_i,
    input  st_we_i,
    input  st_addr_index_i,
    input  st_addr_tag_i,
    input  st_wdata_i,
    input  st_be_i,
    output st_gnt_o
  );

  modport master (
    output ld_req_valid_i,
    output ld_addr_index_i,
    input  ld_gnt_o,
    output ld_tag_valid_i,
    output ld_addr_tag_i,
    output ld_kill_i,
    input  ld_rvalid_o,
    input  ld_rdata_o,
    output st_req_valid_i,
    output st_we_i,
    output st_addr_index_i,
    output st_addr_tag_i,
    output st_wdata_i,
    output st_be_i,
    input  st_gnt_o
  );
endinterface

// File: rtl/lagarto_dcache_responder.sv
// Cache-side responder for the Lagarto split load/store dcache request ports.
//
// Backs both ports with a DEPTH x 64-bit word array. Stores are granted and
// committed in the cycle they are presented; loads follow an index phase
// (grant), a tag phase (array read) and return the containing 8-byte word
// RESP_LAT cycles after the tag cycle as a one-cycle ld_rvalid_o pulse.
// Intended as a stand-in L1 dcache for core-level simulation and FPGA bring-up.
//
// Ports:
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset (array contents are not reset)
//   bus    : lagarto_dcache_responder_if.slave (load and store request ports)
//
// Optional build macro LAGARTO_DCACHE_RESP_STALL_EN: a 16-bit LFSR
// (x^16+x^14+x^13+x^11+1, seed 16'hACE1) randomly masks grants (bit0 load,
// bit1 store) and adds LFSR[3:2] extra cycles of load latency. Without the
// macro grants are purely combinational and latency is fixed at RESP_LAT.
module lagarto_dcache_responder #(
  parameter int unsigned INDEX_W  = 12,
  parameter int unsigned TAG_W    = 44,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  lagarto_dcache_responder_if.slave   bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = TAG_W + INDEX_W;
  // Wide enough for the worst-case reload of RESP_LAT + 3.
  localparam int unsigned CntW = $clog2(RESP_LAT + 4);

  typedef enum logic [1:0] {
    StIdle,
    StTag,
    StWait
  } ld_state_e;

  // Word address is paddr[3 +: AW]; higher physical address bits alias (wrap).
  function automatic logic [AW-1:0] word_addr(input logic [TAG_W-1:0]   tag,
                                               input logic [INDEX_W-1:0] index);
    logic [PW-1:0] paddr;
    paddr = {tag, index};
    return paddr[3 +: AW];
  endfunction

  // ---------------------------------------------------------------------------
  // Grant stall source
  // ---------------------------------------------------------------------------
  logic       ld_stall;
  logic       st_stall;
  logic [1:0] lat_extra;

`ifdef LAGARTO_DCACHE_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    ld_stall  = lfsr_q[0];
    st_stall  = lfsr_q[1];
    lat_extra = lfsr_q[3:2];
  end
`else
  always_comb begin
    ld_stall  = 1'b0;
    st_stall  = 1'b0;
    lat_extra = 2'd0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Store port and backing array
  // ---------------------------------------------------------------------------
  logic          st_gnt;
  logic [AW-1:0] st_word;
  logic [63:0]   mem_q [DEPTH];

  // rstn_i gates the grant so every output reads 0 while reset is asserted.
  always_comb begin
    st_gnt  = rstn_i & bus.st_req_valid_i & bus.st_we_i & ~st_stall;
    st_word = word_addr(bus.st_addr_tag_i, bus.st_addr_index_i);
  end

  always_ff @(posedge clk_i) begin
    if (st_gnt) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.st_be_i[i]) begin
          mem_q[st_word][8*i +: 8] <= bus.st_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  ld_state_e          state_q, state_d;
  logic [INDEX_W-1:0] ld_index_q, ld_index_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [63:0]        ld_data_q, ld_data_d;
  logic [63:0]        rdata_hold_q, rdata_hold_d;

  logic          ld_gnt;
  logic          ld_rvalid;
  logic [AW-1:0] ld_word;
  logic [63:0]   ld_merged;

  // Array word for the tag cycle, with a same-cycle granted store to the same
  // word forwarded byte-by-byte (the array itself only updates at the edge).
  always_comb begin
    ld_word   = word_addr(bus.ld_addr_tag_i, ld_index_q);
    ld_merged = mem_q[ld_word];
    if (st_gnt && (st_word == ld_word)) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.st_be_i[i]) begin
          ld_merged[8*i +: 8] = bus.st_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_index_d   = ld_index_q;
    cnt_d        = cnt_q;
    ld_data_d    = ld_data_q;
    rdata_hold_d = rdata_hold_q;
    ld_gnt       = 1'b0;
    ld_rvalid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rstn_i && bus.ld_req_valid_i && !ld_stall) begin
          ld_gnt     = 1'b1;
          ld_index_d = bus.ld_addr_index_i;
          state_d    = StTag;
        end
      end
      StTag: begin
        // New index-phase requests are not granted here; the requester holds.
        if (bus.ld_tag_valid_i) begin
          if (bus.ld_kill_i) begin
            state_d = StIdle;
          end else begin
            ld_data_d = ld_merged;
            cnt_d     = CntW'(RESP_LAT) + CntW'(lat_extra);
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        // Kill wins even in the cycle that would have responded.
        if (bus.ld_kill_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntW'(1)) begin
          ld_rvalid    = 1'b1;
          rdata_hold_d = ld_data_q;
          cnt_d        = '0;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      ld_index_q   <= '0;
      cnt_q        <= '0;
      ld_data_q    <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      ld_index_q   <= ld_index_d;
      cnt_q        <= cnt_d;
      ld_data_q    <= ld_data_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // rdata shows the new word during the pulse and holds it afterwards.
  always_comb begin
    bus.ld_gnt_o    = ld_gnt;
    bus.ld_rvalid_o = ld_rvalid;
    bus.ld_rdata_o  = ld_rvalid ? ld_data_q : rdata_hold_q;
    bus.st_gnt_o    = st_gnt;
  end

endmodule
